i2c_target: RTL and testbench

- I2C responder (slave) for the other end of the bus driven by our I2C master. It emulates the IMU register interface for board-level loopback and simulation.
- Address and register pointer are decoded from the bus. Register reads and writes go to an external register file through a simple synchronous port.
- Sits beside the master in loopback builds and shares the same scl/sda nets. No clock stretching.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_bus_sync.sv | 90 +++++++++
 rtl/i2c_target.sv | 190 +++++++++++++++++++
 tb/tb_i2c_target.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
//------------------------------------------------------------------------------
// i2c_pkg : shared I2C constants and responder FSM state encoding.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package i2c_pkg;
  localparam int   BYTE_W = 8;
  localparam logic ACK    = 1'b0;
  localparam logic NACK   = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_REG_PTR   = 4'd3,
    ST_REG_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;
endpackage

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
//------------------------------------------------------------------------------
// i2c_bus_sync : scl/sda synchroniser, optional majority glitch filter
//                (I2C_TARGET_GLITCH_FILTER_EN) and edge/START/STOP detection.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   w_scl_c;
  logic                   w_sda_c;
  logic                   r_scl_prev;
  logic                   r_sda_prev;

  // Reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist;
  logic [1:0] r_sda_hist;
  logic       r_scl_f;
  logic       r_sda_f;
  logic       w_scl_in;
  logic       w_sda_in;

  assign w_scl_in = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_in = r_sda_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_f    <= 1'b1;
      r_sda_f    <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], w_scl_in};
      r_sda_hist <= {r_sda_hist[0], w_sda_in};
      r_scl_f    <= (w_scl_in & r_scl_hist[0]) | (w_scl_in & r_scl_hist[1]) |
                    (r_scl_hist[0] & r_scl_hist[1]);
      r_sda_f    <= (w_sda_in & r_sda_hist[0]) | (w_sda_in & r_sda_hist[1]) |
                    (r_sda_hist[0] & r_sda_hist[1]);
    end
  end

  assign w_scl_c = r_scl_f;
  assign w_sda_c = r_sda_f;
`else
  assign w_scl_c = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_c = r_sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl_c;
      r_sda_prev <= w_sda_c;
    end
  end

  assign scl_rise  = w_scl_c & ~r_scl_prev;
  assign scl_fall  = ~w_scl_c & r_scl_prev;
  assign start_det = w_scl_c & r_scl_prev & r_sda_prev & ~w_sda_c;
  assign stop_det  = w_scl_c & r_scl_prev & ~r_sda_prev & w_sda_c;
  assign sda_s     = w_sda_c;
endmodule

`default_nettype wire

// File: rtl/i2c_target.sv
//------------------------------------------------------------------------------
// i2c_target : I2C register-interface responder, no clock stretching.
//              Optional input glitch filter: I2C_TARGET_GLITCH_FILTER_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h68,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  inout  wire               sda,
  output logic [BYTE_W-1:0] reg_addr,
  input  logic [BYTE_W-1:0] reg_rdata,
  output logic              wr_en,
  output logic [BYTE_W-1:0] wr_addr,
  output logic [BYTE_W-1:0] wr_data,
  output logic              busy,
  output logic [3:0]        state_ind
);
  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_bitcnt;
  logic [BYTE_W-1:0] r_shift;
  logic              r_rw;
  logic              r_ack_phase;
  logic              r_load_pend;
  logic              r_sda_low;
  logic [BYTE_W-1:0] r_reg_addr;
  logic              r_wr_en;
  logic [BYTE_W-1:0] r_wr_addr;
  logic [BYTE_W-1:0] r_wr_data;
  logic              r_busy;

  logic              w_scl_rise;
  logic              w_scl_fall;
  logic              w_start;
  logic              w_stop;
  logic              w_sda_s;
  logic [BYTE_W-1:0] w_byte;
  logic              w_last;
  logic              w_match;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop),
    .sda_s     (w_sda_s)
  );

  assign w_byte  = {r_shift[BYTE_W-2:0], w_sda_s};
  assign w_last  = (r_bitcnt == 3'd7);
  assign w_match = (w_byte[7:1] == TARGET_ADDR);

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ST_ADDR;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_ADDR: if (w_scl_rise && w_last) begin
          if (w_match) w_state_nxt = ST_ADDR_ACK;
          else         w_state_nxt = ST_IDLE;
        end
        ST_ADDR_ACK: if (w_scl_fall && r_ack_phase) begin
          if (r_rw) w_state_nxt = ST_RDATA;
          else      w_state_nxt = ST_REG_PTR;
        end
        ST_REG_PTR:   if (w_scl_rise && w_last)     w_state_nxt = ST_REG_ACK;
        ST_REG_ACK:   if (w_scl_fall && r_ack_phase) w_state_nxt = ST_WDATA;
        ST_WDATA:     if (w_scl_rise && w_last)     w_state_nxt = ST_WDATA_ACK;
        ST_WDATA_ACK: if (w_scl_fall && r_ack_phase) w_state_nxt = ST_WDATA;
        ST_RDATA: if (w_scl_fall && !r_load_pend && w_last) w_state_nxt = ST_RDATA_ACK;
        ST_RDATA_ACK: if (w_scl_rise) begin
          if (w_sda_s == NACK) w_state_nxt = ST_WAIT_STOP;
          else                 w_state_nxt = ST_RDATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_rw        <= 1'b0;
      r_ack_phase <= 1'b0;
      r_load_pend <= 1'b0;
      r_sda_low   <= 1'b0;
      r_reg_addr  <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_start || w_stop) begin
        r_bitcnt    <= '0;
        r_sda_low   <= 1'b0;
        r_ack_phase <= 1'b0;
        r_load_pend <= 1'b0;
        if (w_stop) r_busy <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR, ST_REG_PTR, ST_WDATA: if (w_scl_rise) begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (w_last) begin
              r_ack_phase <= 1'b0;
              if (r_state == ST_ADDR) begin
                r_busy <= w_match;
                r_rw   <= w_byte[0];
              end else if (r_state == ST_REG_PTR) begin
                r_reg_addr <= w_byte;
              end else begin
                r_wr_en    <= 1'b1;
                r_wr_addr  <= r_reg_addr;
                r_wr_data  <= w_byte;
                r_reg_addr <= r_reg_addr + 8'd1;
              end
            end
          end
          // First fall after the 8th bit pulls sda low, the next one releases it.
          ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: if (w_scl_fall) begin
            if (!r_ack_phase) begin
              r_sda_low   <= 1'b1;
              r_ack_phase <= 1'b1;
            end else begin
              r_ack_phase <= 1'b0;
              r_bitcnt    <= '0;
              if (r_state == ST_ADDR_ACK && r_rw) begin
                r_shift   <= reg_rdata;
                r_sda_low <= ~reg_rdata[7];
              end else begin
                r_sda_low <= 1'b0;
              end
            end
          end
          ST_RDATA: if (w_scl_fall) begin
            if (r_load_pend) begin
              r_load_pend <= 1'b0;
              r_bitcnt    <= '0;
              r_shift     <= reg_rdata;
              r_sda_low   <= ~reg_rdata[7];
            end else if (w_last) begin
              r_sda_low <= 1'b0;
            end else begin
              r_shift   <= {r_shift[BYTE_W-2:0], 1'b0};
              r_sda_low <= ~r_shift[6];
              r_bitcnt  <= r_bitcnt + 3'd1;
            end
          end
          ST_RDATA_ACK: if (w_scl_rise && (w_sda_s == ACK)) begin
            r_reg_addr  <= r_reg_addr + 8'd1;
            r_load_pend <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign sda       = r_sda_low ? 1'b0 : 1'bz;
  assign reg_addr  = r_reg_addr;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign state_ind = r_state;
endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
//------------------------------------------------------------------------------
// tb_i2c_target : bit-banged I2C master against a register-file model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2c_target;
  localparam int         Q    = 10;
  localparam logic [6:0] ADDR = 7'h68;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  wire        sda;
  logic [7:0] reg_addr;
  logic [7:0] reg_rdata = 8'h00;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [3:0] state_ind;

  pullup (sda);
  assign sda = m_sda ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  i2c_target #(.TARGET_ADDR(ADDR), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .reg_addr  (reg_addr),
    .reg_rdata (reg_rdata),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .state_ind (state_ind)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model [256];
  logic [7:0] rf    [256];
  logic       load_rf = 1'b0;
  logic [7:0] mptr = 8'h00;
  logic [7:0] wbuf [4];
  logic [15:0] wq [$];
  int         sda_low_cnt = 0;
  int         busy_cnt = 0;

  // External register file; read data lags the address by one clock.
  always @(posedge clk) begin
    if (load_rf) begin
      for (int i = 0; i < 256; i++) rf[i] <= model[i];
    end else if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
    reg_rdata <= rf[reg_addr];
  end

  always @(negedge clk) begin
    if (wr_en) wq.push_back({wr_addr, wr_data});
    if (sda == 1'b0 && m_sda) sda_low_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sync_rf();
    load_rf = 1'b1;
    tick(1);
    load_rf = 1'b0;
    tick(1);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; tick(Q);
    scl   = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; tick(Q);
    scl   = 1'b1; tick(2 * Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    b     = sda;  tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack_bit);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack_bit);
  endtask

  task automatic do_write(input logic [7:0] ptr, input int n);
    logic        a;
    logic [15:0] exp [$];
    wq.delete();
    bus_start();
    send_byte({ADDR, 1'b0}, a); check("wr_addr_ack", a, 0);
    send_byte(ptr, a);          check("wr_ptr_ack", a, 0);
    mptr = ptr;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], a);    check("wr_data_ack", a, 0);
      exp.push_back({mptr, wbuf[i]});
      model[mptr] = wbuf[i];
      mptr = mptr + 8'd1;
    end
    check("wr_busy_before_stop", busy, 1);
    bus_stop();
    tick(8);
    check("wr_pulse_count", wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++) check("wr_addr_data", wq[i], exp[i]);
    check("wr_ptr_after", reg_addr, mptr);
    check("wr_busy_after_stop", busy, 0);
    check("wr_idle", state_ind, 0);
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] ptr, input int n);
    logic       a;
    logic [7:0] d;
    bus_start();
    if (set_ptr) begin
      send_byte({ADDR, 1'b0}, a); check("rd_waddr_ack", a, 0);
      send_byte(ptr, a);          check("rd_ptr_ack", a, 0);
      mptr = ptr;
      bus_start();
    end
    send_byte({ADDR, 1'b1}, a);   check("rd_raddr_ack", a, 0);
    for (int i = 0; i < n; i++) begin
      recv_byte(d, (i == n - 1));
      check("rd_data", d, model[mptr]);
      if (i != n - 1) mptr = mptr + 8'd1;
    end
    check("rd_wait_stop", state_ind, 9);
    check("rd_busy_before_stop", busy, 1);
    bus_stop();
    tick(8);
    check("rd_busy_after_stop", busy, 0);
    check("rd_ptr_after", reg_addr, mptr);
  endtask

  task automatic do_foreign(input logic [6:0] addr);
    logic a;
    sda_low_cnt = 0;
    busy_cnt    = 0;
    bus_start();
    send_byte({addr, 1'($urandom_range(0, 1))}, a);
    check("foreign_nack", a, 1);
    send_byte(8'($urandom), a);
    bus_stop();
    tick(8);
    check("foreign_sda_released", sda_low_cnt, 0);
    check("foreign_busy_low", busy_cnt, 0);
    check("foreign_idle", state_ind, 0);
  endtask

  initial begin
    logic       a;
    int         op;
    logic [6:0] fa;

    for (int i = 0; i < 256; i++) model[i] = 8'($urandom);
    tick(4);
    check("rst_state", state_ind, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_sda", sda, 1);
    rst = 1'b0;
    sync_rf();
    tick(10);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    m_sda = 1'b0; tick(1);
    m_sda = 1'b1; tick(12);
    check("glitch_no_start", state_ind, 0);
`endif

    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h3C;
    do_write(8'h12, 2);

    model[8'h16] = 8'h11;
    model[8'h17] = 8'h22;
    sync_rf();
    do_read(1'b1, 8'h16, 2);

    do_foreign(7'h50);

    do_read(1'b1, 8'hFF, 2);
    check("wrap_ptr_zero", reg_addr, 8'h00);

    do_read(1'b0, 8'h00, 2);

    // Reset while the responder is driving a 0 data bit.
    model[8'h40] = 8'h00;
    sync_rf();
    bus_start();
    send_byte({ADDR, 1'b0}, a);
    send_byte(8'h40, a);
    bus_start();
    send_byte({ADDR, 1'b1}, a);
    check("rdata_drive_low", sda, 0);
    rst = 1'b1;
    tick(1);
    check("midrst_sda", sda, 1);
    check("midrst_state", state_ind, 0);
    check("midrst_reg_addr", reg_addr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_wr_en", wr_en, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_wr_data", wr_data, 0);
    tick(2);
    rst  = 1'b0;
    mptr = 8'h00;
    scl  = 1'b1;
    tick(Q);

    for (int t = 0; t < 12; t++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        do_write(8'($urandom), $urandom_range(1, 3));
      end else if (op == 1) begin
        do_read(1'b1, 8'($urandom), $urandom_range(1, 3));
      end else if (op == 2) begin
        do_read(1'b0, 8'h00, $urandom_range(1, 3));
      end else begin
        fa = 7'($urandom);
        if (fa == ADDR) fa = fa + 7'd1;
        do_foreign(fa);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

`default_nettype wire
